multicycle_controller: RTL and testbench

Sequencing FSM for the multicycle RV32I core. Replaces the single-cycle decode path with a per-instruction state walk (fetch, decode, execute, memory, writeback) over a shared ALU and a unified instruction/data memory port. The memory handshake stretches any state that touches memory. Sits between the instruction register and the datapath muxes/enables, and reuses the existing ALU decode for `alucontrol`.

---
 rtl/mc_ctrl_pkg.sv | 79 +++++++
 rtl/alu_decoder.sv | 36 +++
 rtl/multicycle_controller.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types, encodings and decode helper for the multicycle controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRJ,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Successor of DECODE; only beq/bne are supported among branches.
    function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] funct3);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXECR;
            OP_ITYPE:          return S_EXECI;
            OP_BRANCH:         return (funct3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR;
            OP_LUI:            return S_LUI;
            default:           return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps aluop/funct3/funct7 onto the ALU operation code
// Ports: i_aluop (00 add, 01 sub, 10 funct), i_funct3, i_funct7 in; o_alucontrol out.
// The caller must present funct7 as zero for I-type ops other than shifts.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [3:0] o_alucontrol
);

    logic w_unused_funct7;
    assign w_unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            default: begin
                case (i_funct3)
                    3'b000:  o_alucontrol = i_funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alucontrol = ALU_SLL;
                    3'b010:  o_alucontrol = ALU_SLT;
                    3'b011:  o_alucontrol = ALU_SLTU;
                    3'b100:  o_alucontrol = ALU_XOR;
                    3'b101:  o_alucontrol = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  o_alucontrol = ALU_OR;
                    default: o_alucontrol = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - per-instruction sequencing FSM for the multicycle RV32I core
// Ports: clk, rst (sync, active high), instr, zero, mem_ready in;
//        pcwrite, adrsrc, irwrite, memread, memwrite, regwrite, alusrca, alusrcb,
//        immsrc, resultsrc, alucontrol, retire, illegal out.
// Optional MC_PERF_COUNTERS_EN adds cycle_count and instret_count outputs.
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        adrsrc,
    output logic        irwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        regwrite,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  immsrc,
    output logic [1:0]  resultsrc,
    output logic [3:0]  alucontrol,
    output logic        retire,
    output logic        illegal
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    state_t     r_state;
    logic [1:0] w_aluop;
    logic [6:0] w_funct7;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    // I-type immediates occupy the funct7 field; only shifts carry a real funct7,
    // so hide it otherwise to keep e.g. addi with imm[10]=1 from decoding as sub.
    assign w_funct7 = (instr[5] || (w_funct3 == 3'b101)) ? instr[31:25] : 7'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE:   r_state <= decode_next(w_opcode, w_funct3);
                S_MEMADR:   r_state <= instr[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_MEMWB, S_ALUWB, S_BRANCH: r_state <= S_FETCH;
                S_EXECR, S_EXECI, S_JAL, S_JALRJ, S_LUI: r_state <= S_ALUWB;
                S_JALR:     r_state <= S_JALRJ;
                default:    r_state <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        immsrc    = IMM_I;
        resultsrc = RES_ALUOUT;
        retire    = 1'b0;
        illegal   = 1'b0;
        w_aluop   = ALUOP_ADD;
        // Reset overrides the state decode in the same cycle so a held
        // memory request or pending writeback never leaks out.
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    memread = 1'b1;
                    if (mem_ready) begin
                        irwrite   = 1'b1;
                        pcwrite   = 1'b1;
                        alusrcb   = SRCB_FOUR;
                        resultsrc = RES_ALU;
                    end
                end
                S_DECODE: begin
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_IMM;
                    immsrc  = (w_opcode == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEMADR: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_IMM;
                    immsrc  = instr[5] ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    adrsrc  = 1'b1;
                    memread = 1'b1;
                end
                S_MEMWB: begin
                    resultsrc = RES_DATA;
                    regwrite  = 1'b1;
                    retire    = 1'b1;
                end
                S_MEMWRITE: begin
                    adrsrc   = 1'b1;
                    memwrite = 1'b1;
                    retire   = mem_ready;
                end
                S_EXECR: begin
                    alusrca = SRCA_RS1;
                    w_aluop = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_IMM;
                    w_aluop = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca = SRCA_RS1;
                    w_aluop = ALUOP_SUB;
                    retire  = 1'b1;
                    pcwrite = w_funct3[0] ? !zero : zero;
                end
                S_JAL: begin
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_FOUR;
                    pcwrite = 1'b1;
                end
                S_JALR: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_IMM;
                end
                S_JALRJ: begin
                    pcwrite = 1'b1;
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_FOUR;
                end
                S_LUI: begin
                    alusrca = SRCA_ZERO;
                    alusrcb = SRCB_IMM;
                    immsrc  = IMM_U;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct3     (w_funct3),
        .i_funct7     (w_funct7),
        .o_alucontrol (alucontrol)
    );

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instret_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count   <= 32'd0;
            r_instret_count <= 32'd0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (retire) r_instret_count <= r_instret_count + 32'd1;
        end
    end

    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst, zero, mem_ready;
    logic [31:0] instr;
    logic        pcwrite, adrsrc, irwrite, memread, memwrite, regwrite, retire, illegal;
    logic [1:0]  alusrca, alusrcb, resultsrc;
    logic [2:0]  immsrc;
    logic [3:0]  alucontrol;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_count, instret_count;
`endif

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .memread    (memread),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .resultsrc  (resultsrc),
        .alucontrol (alucontrol),
        .retire     (retire),
        .illegal    (illegal)
`ifdef MC_PERF_COUNTERS_EN
        ,
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
`endif
    );

    typedef struct packed {
        logic       pcw, adr, irw, mrd, mwr, rgw, ret, ill;
        logic [1:0] a, b;
        logic [2:0] imm;
        logic [1:0] res;
        logic [3:0] alu;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   waits;
        bit   br;
        bit   bne;
    } step_t;

    obs_t    got;
    step_t   steps[$];
    int      tests = 0;
    int      fails = 0;
    bit      rand_mode = 1'b0;
    bit      zero_one = 1'b0;

    assign got = {pcwrite, adrsrc, irwrite, memread, memwrite, regwrite, retire, illegal,
                  alusrca, alusrcb, immsrc, resultsrc, alucontrol};

    function automatic obs_t ob(input bit pcw, adr, irw, mrd, mwr, rgw, ret,
                                input logic [1:0] a, b, input logic [2:0] imm,
                                input logic [1:0] res, input logic [3:0] alu);
        obs_t o;
        o.pcw = pcw; o.adr = adr; o.irw = irw; o.mrd = mrd; o.mwr = mwr;
        o.rgw = rgw; o.ret = ret; o.ill = 1'b0;
        o.a = a; o.b = b; o.imm = imm; o.res = res; o.alu = alu;
        return o;
    endfunction

    // ALU operation implied by the RV32I mnemonic of an R/I arithmetic instruction.
    function automatic logic [3:0] alu_of(input logic [31:0] ins);
        bit r;
        r = (ins[6:0] == 7'b0110011);
        case (ins[14:12])
            3'd0:    return (r && ins[30]) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return ins[30] ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic void push(input obs_t o, input bit w = 1'b0, input bit br = 1'b0,
                                 input bit bne = 1'b0);
        step_t s;
        s.o = o; s.waits = w; s.br = br; s.bne = bne;
        steps.push_back(s);
    endfunction

    // Expected per-cycle outputs for one instruction, listed as its sequence of steps.
    function automatic void build(input logic [31:0] ins);
        logic [6:0] op;
        obs_t       wb, trap;
        op = ins[6:0];
        wb = ob(0,0,0,0,0,1,1, 2'd0,2'd0,3'd0,2'd0,4'd0);
        trap = '0;
        trap.ill = 1'b1;
        steps.delete();
        push(ob(1,0,1,1,0,0,0, 2'd0,2'd2,3'd0,2'd2,4'd0), 1'b1);
        push(ob(0,0,0,0,0,0,0, 2'd1,2'd1,(op == 7'b1101111) ? 3'd3 : 3'd2,2'd0,4'd0));
        case (op)
            7'b0110011: begin push(ob(0,0,0,0,0,0,0, 2'd2,2'd0,3'd0,2'd0,alu_of(ins))); push(wb); end
            7'b0010011: begin push(ob(0,0,0,0,0,0,0, 2'd2,2'd1,3'd0,2'd0,alu_of(ins))); push(wb); end
            7'b0000011: begin
                push(ob(0,0,0,0,0,0,0, 2'd2,2'd1,3'd0,2'd0,4'd0));
                push(ob(0,1,0,1,0,0,0, 2'd0,2'd0,3'd0,2'd0,4'd0), 1'b1);
                push(ob(0,0,0,0,0,1,1, 2'd0,2'd0,3'd0,2'd1,4'd0));
            end
            7'b0100011: begin
                push(ob(0,0,0,0,0,0,0, 2'd2,2'd1,3'd1,2'd0,4'd0));
                push(ob(0,1,0,0,1,0,1, 2'd0,2'd0,3'd0,2'd0,4'd0), 1'b1);
            end
            7'b1100011: begin
                if (ins[14:13] == 2'b00)
                    push(ob(0,0,0,0,0,0,1, 2'd2,2'd0,3'd0,2'd0,4'd1), 1'b0, 1'b1, ins[12]);
                else
                    push(trap);
            end
            7'b1101111: begin push(ob(1,0,0,0,0,0,0, 2'd1,2'd2,3'd0,2'd0,4'd0)); push(wb); end
            7'b1100111: begin
                push(ob(0,0,0,0,0,0,0, 2'd2,2'd1,3'd0,2'd0,4'd0));
                push(ob(1,0,0,0,0,0,0, 2'd1,2'd2,3'd0,2'd0,4'd0));
                push(wb);
            end
            7'b0110111: begin push(ob(0,0,0,0,0,0,0, 2'd3,2'd1,3'd4,2'd0,4'd0)); push(wb); end
            default:    push(trap);
        endcase
    endfunction

    // While the memory stalls only the request half of a step is visible.
    function automatic obs_t wait_of(input obs_t o);
        obs_t w;
        w = o;
        w.pcw = 1'b0; w.irw = 1'b0; w.ret = 1'b0; w.b = 2'd0; w.res = 2'd0;
        return w;
    endfunction

    task automatic cyc(input step_t s, input logic [31:0] ins, input bit rdy, input bit rs,
                       input string tag);
        obs_t e;
        @(negedge clk);
        rst = rs;
        instr = ins;
        mem_ready = rdy;
        zero = zero_one ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        e = s.o;
        if (s.waits && !rdy) e = wait_of(e);
        if (s.br) e.pcw = s.bne ? !zero : zero;
        if (rs) e = '0;
        tests++;
        assert (got === e) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, e);
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input string tag, output int ncyc);
        build(ins);
        ncyc = 0;
        foreach (steps[i]) begin
            int  nw;
            bit  rdy;
            nw = 0;
            do begin
                if (!steps[i].waits) rdy = 1'($urandom_range(0, 1));
                else if (rand_mode)  rdy = (nw >= 4) || ($urandom_range(0, 2) != 0);
                else                 rdy = (nw >= ((i == 0) ? fw : mw));
                cyc(steps[i], ins, rdy, 1'b0, tag);
                ncyc++;
                nw++;
            end while (steps[i].waits && !rdy);
        end
    endtask

    task automatic check_int(input int g, input int e, input string tag);
        tests++;
        assert (g === e) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, g, e);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [19:0] up;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        f3 = 3'($urandom); imm = 12'($urandom); up = 20'($urandom);
        case ($urandom_range(0, 8))
            0: return {((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                       rs2, rs1, f3, rd, 7'b0110011};
            1: begin
                if (f3 == 3'd1) imm[11:5] = 7'h00;
                if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return {imm, rs1, f3, rd, 7'b0010011};
            end
            2: return {imm, rs1, 3'b010, rd, 7'b0000011};
            3: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            4: return {imm[11:5], rs2, rs1, 2'b00, f3[0], imm[4:0], 7'b1100011};
            5: return {up, rd, 7'b1101111};
            6: return {imm, rs1, 3'b000, rd, 7'b1100111};
            7: return {up, rd, 7'b0110111};
            default: return {1'b0, 1'b1, imm[9:0], rs1, 3'b000, rd, 7'b0010011};
        endcase
    endfunction

    initial begin
        int          n;
        logic [31:0] ins;
        step_t       fs;
        rst = 1'b1; instr = 32'd0; mem_ready = 1'b0; zero = 1'b0;

        build(32'h002081B3);
        cyc(steps[0], 32'h002081B3, 1'b1, 1'b1, "reset_a");
        cyc(steps[0], 32'h0000A283, 1'b0, 1'b1, "reset_b");

        run_instr(32'h002081B3, 0, 0, "add", n);
        check_int(n, 4, "add_cycles");

        run_instr(32'h0000A283, 0, 2, "lw_wait", n);
        check_int(n, 7, "lw_cycles");

        zero_one = 1'b1;
        run_instr(32'h00208063, 0, 0, "beq_z1", n);
        check_int(n, 3, "beq_cycles");
        run_instr(32'h00209063, 0, 0, "bne_z1", n);
        check_int(n, 3, "bne_cycles");
        zero_one = 1'b0;

        run_instr(32'h00000537, 0, 0, "lui", n);
        check_int(n, 4, "lui_cycles");
        run_instr(32'h000080E7, 0, 0, "jalr", n);
        check_int(n, 5, "jalr_cycles");
        run_instr(32'h0020A023, 1, 0, "sw_fw", n);
        check_int(n, 5, "sw_fetchwait_cycles");

        // Store interrupted by reset during its second memory wait.
        build(32'h0020A023);
        cyc(steps[0], 32'h0020A023, 1'b1, 1'b0, "sw_fetch");
        cyc(steps[1], 32'h0020A023, 1'b1, 1'b0, "sw_decode");
        cyc(steps[2], 32'h0020A023, 1'b1, 1'b0, "sw_memadr");
        cyc(steps[3], 32'h0020A023, 1'b0, 1'b0, "sw_wait1");
        cyc(steps[3], 32'h0020A023, 1'b0, 1'b1, "sw_rst");
        fs = steps[0];
        cyc(fs, 32'h0020A023, 1'b0, 1'b0, "sw_refetch");

        rand_mode = 1'b1;
        for (int k = 0; k < 80; k++) begin
            ins = rand_instr();
            run_instr(ins, 0, 0, "rand", n);
        end
        rand_mode = 1'b0;

        // ecall is unsupported: absorbing trap until reset.
        build(32'h00000073);
        cyc(steps[0], 32'h00000073, 1'b1, 1'b0, "ecall_fetch");
        cyc(steps[1], 32'h00000073, 1'b1, 1'b0, "ecall_decode");
        for (int k = 0; k < 20; k++)
            cyc(steps[2], 32'h00000073, 1'($urandom_range(0, 1)), 1'b0, "trap_hold");
        cyc(steps[2], 32'h00000073, 1'b1, 1'b1, "trap_rst");
        run_instr(32'h002081B3, 0, 0, "add_after_trap", n);
        check_int(n, 4, "add_after_trap_cycles");

`ifdef MC_PERF_COUNTERS_EN
        build(32'h002081B3);
        cyc(steps[0], 32'h002081B3, 1'b1, 1'b1, "perf_rst");
        @(negedge clk);
        #1;
        check_int(int'(cycle_count), 0, "cycle_count_reset");
        check_int(int'(instret_count), 0, "instret_count_reset");
        for (int k = 0; k < 10; k++) run_instr(32'h002081B3, 0, 0, "perf_add", n);
        @(negedge clk);
        #1;
        check_int(int'(instret_count), 10, "instret_count");
        check_int(int'(cycle_count), 40, "cycle_count");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
